// File: rtl/dt_pkg.sv
// Shared types and constants for the two-pass chessboard distance transform sequencer.
package dt_pkg;
  localparam int LOG_W_DEF  = 7;
  localparam int ADDR_W_DEF = 2 * LOG_W_DEF;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {IDLE, RD_C, CHK, RD_N, LAST, WR, DONE} state_e;
  typedef enum logic {FWD = 1'b0, BWD = 1'b1} pass_e;

  // Neighbour row/col deltas in visit order, indexed [pass][nb]:
  // forward NW,N,NE,W (-129,-128,-127,-1); backward SE,S,SW,E (+129,+128,+127,+1).
  localparam logic signed [1:0] NBR_DR [2][4] = '{'{-2'sd1, -2'sd1, -2'sd1,  2'sd0},
                                                  '{ 2'sd1,  2'sd1,  2'sd1,  2'sd0}};
  localparam logic signed [1:0] NBR_DC [2][4] = '{'{-2'sd1,  2'sd0,  2'sd1, -2'sd1},
                                                  '{ 2'sd1,  2'sd0, -2'sd1,  2'sd1}};

  localparam int SCAN_FIRST = 1;

  function automatic int scan_last(input int log_w);
    return (1 << log_w) - 2;
  endfunction
endpackage

// File: rtl/dt_addr_gen.sv
// Interior raster scan position for both passes; yields centre, next centre and neighbour addresses.
module dt_addr_gen
  import dt_pkg::*;
#(
  parameter int LOG_W = LOG_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               init,
  input  logic               advance,
  input  logic [1:0]         nb,
  output pass_e              pass,
  output logic               last_pixel,
  output logic [2*LOG_W-1:0] centre,
  output logic [2*LOG_W-1:0] centre_nxt,
  output logic [2*LOG_W-1:0] nbr_addr
);
  localparam logic [LOG_W-1:0] C_FIRST = LOG_W'(SCAN_FIRST);
  localparam logic [LOG_W-1:0] C_LAST  = LOG_W'(scan_last(LOG_W));

  logic [LOG_W-1:0] row_q, row_d, col_q, col_d;
  pass_e            pass_q, pass_d;
  logic [LOG_W-1:0] dr, dc;

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    pass_d = pass_q;
    if (init) begin
      row_d  = C_FIRST;
      col_d  = C_FIRST;
      pass_d = FWD;
    end else if (advance) begin
      if (pass_q == FWD) begin
        if (col_q != C_LAST) begin
          col_d = col_q + 1'b1;
        end else if (row_q != C_LAST) begin
          col_d = C_FIRST;
          row_d = row_q + 1'b1;
        end else begin
          // Backward pass starts on the pixel where the forward pass ended.
          pass_d = BWD;
        end
      end else begin
        if (col_q != C_FIRST) begin
          col_d = col_q - 1'b1;
        end else begin
          col_d = C_LAST;
          row_d = row_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q  <= '0;
      col_q  <= '0;
      pass_q <= FWD;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      pass_q <= pass_d;
    end
  end

  assign dr         = {{(LOG_W-2){NBR_DR[pass_q][nb][1]}}, NBR_DR[pass_q][nb]};
  assign dc         = {{(LOG_W-2){NBR_DC[pass_q][nb][1]}}, NBR_DC[pass_q][nb]};
  assign pass       = pass_q;
  assign centre     = {row_q, col_q};
  assign centre_nxt = {row_d, col_d};
  assign nbr_addr   = {row_q + dr, col_q + dc};
  assign last_pixel = (pass_q == FWD) ? ((row_q == C_LAST) && (col_q == C_LAST))
                                      : ((row_q == C_FIRST) && (col_q == C_FIRST));
endmodule

// File: rtl/dt_pass_sequencer.sv
// Forward/backward chessboard distance transform over the result RAM; sole RAM master once started.
module dt_pass_sequencer
  import dt_pkg::*;
#(
  parameter int LOG_W  = LOG_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              res_rd,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [DATA_W-1:0] res_di,
  output logic              res_wr,
  output logic [DATA_W-1:0] res_do,
  output logic              busy,
  output logic              done
);
  state_e            state_q, state_d;
  logic [1:0]        nb_q, nb_d;
  logic [DATA_W-1:0] acc_q, acc_d, cen_q, cen_d, do_q, do_d, inc;
  logic [ADDR_W-1:0] addr_q, addr_d, centre, centre_nxt, nbr_addr;
  logic              rd_q, rd_d, wr_q, wr_d, busy_q, busy_d, done_q, done_d;
  logic              init, advance, last_pixel;
  pass_e             pass;

  function automatic logic [DATA_W-1:0] umin(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  dt_addr_gen #(.LOG_W(LOG_W)) u_addr_gen (
    .clk       (clk),
    .rstn      (rstn),
    .init      (init),
    .advance   (advance),
    .nb        (nb_d),
    .pass      (pass),
    .last_pixel(last_pixel),
    .centre    (centre),
    .centre_nxt(centre_nxt),
    .nbr_addr  (nbr_addr)
  );

  always_comb begin
    state_d = state_q;
    nb_d    = nb_q;
    acc_d   = acc_q;
    cen_d   = cen_q;
    init    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        init    = 1'b1;
        state_d = RD_C;
      end
      RD_C: state_d = CHK;
      CHK: if (res_di == '0) begin
        if (last_pixel && (pass == BWD)) state_d = DONE;
        else begin
          advance = 1'b1;
          state_d = RD_C;
        end
      end else begin
        cen_d   = res_di;
        acc_d   = '1;
        nb_d    = 2'd0;
        state_d = RD_N;
      end
      RD_N: begin
        // Read data trails the address by one cycle, so nb=0 has nothing to fold in yet.
        if (nb_q != 2'd0) acc_d = umin(acc_q, res_di);
        if (nb_q == 2'd3) state_d = LAST;
        else              nb_d    = nb_q + 2'd1;
      end
      LAST: begin
        acc_d   = umin(acc_q, res_di);
        state_d = WR;
      end
      WR: if (last_pixel && (pass == BWD)) state_d = DONE;
      else begin
        advance = 1'b1;
        state_d = RD_C;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    inc    = (acc_d == '1) ? acc_d : acc_d + 1'b1;
    rd_d   = 1'b0;
    wr_d   = 1'b0;
    addr_d = '0;
    do_d   = '0;
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
    case (state_d)
      RD_C: begin
        rd_d   = 1'b1;
        addr_d = centre_nxt;
      end
      RD_N: begin
        rd_d   = 1'b1;
        addr_d = nbr_addr;
      end
      WR: begin
        wr_d   = 1'b1;
        addr_d = centre;
        do_d   = (pass == FWD) ? inc : umin(cen_q, inc);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      nb_q    <= '0;
      acc_q   <= '0;
      cen_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      do_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nb_q    <= nb_d;
      acc_q   <= acc_d;
      cen_q   <= cen_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      do_q    <= do_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign res_rd   = rd_q;
  assign res_wr   = wr_q;
  assign res_addr = addr_q;
  assign res_do   = do_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_dt_pass_sequencer.sv
// Bench for dt_pass_sequencer: RAM model, protocol monitor, golden DT model and probe table.
module tb_dt_pass_sequencer;
  localparam int LOG_W  = 7;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int W      = 128;
  localparam int NPIX   = W * W;
  localparam int FO [4] = '{-129, -128, -127, -1};
  localparam int BO [4] = '{129, 128, 127, 1};

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              res_rd, res_wr, busy, done;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_di, res_do;

  dt_pass_sequencer #(.LOG_W(LOG_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .res_rd  (res_rd),
    .res_addr(res_addr),
    .res_di  (res_di),
    .res_wr  (res_wr),
    .res_do  (res_do),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem     [NPIX];
  logic [7:0] img     [NPIX];
  logic [7:0] gold    [NPIX];
  logic [7:0] fwd_val [NPIX];
  int         wr_cnt  [NPIX];
  logic       load_req = 1'b0;
  logic       mon_clr  = 1'b0;
  int         n_obj = 0;

  // RAM: registered read, junk on cycles without a read so stray consumption shows up.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < NPIX; i++) begin
        mem[i]     <= img[i];
        fwd_val[i] <= 8'd0;
        wr_cnt[i]  <= 0;
      end
      res_di <= 8'd0;
    end else begin
      if (res_wr) begin
        mem[res_addr] <= res_do;
        if (wr_cnt[res_addr] == 0) fwd_val[res_addr] <= res_do;
        wr_cnt[res_addr] <= wr_cnt[res_addr] + 1;
      end
      res_di <= res_rd ? mem[res_addr] : 8'($urandom);
    end
  end

  int          rd_n, wr_n, both_n, border_n, proto_n, first_rd;
  logic        h_rd [7];
  logic        h_wr [7];
  logic [13:0] h_addr [7];

  function automatic logic is_border(input logic [13:0] a);
    return (a[13:7] == 7'd0) || (a[13:7] == 7'd127) || (a[6:0] == 7'd0) || (a[6:0] == 7'd127);
  endfunction

  // Object pixel strobe history: RD_C, CHK, 4x RD_N, LAST, then this WR.
  function automatic logic seq_ok(input logic bwd, input logic [13:0] c);
    logic ok;
    ok = h_rd[6] && !h_wr[6] && (h_addr[6] == c);
    ok = ok && !h_rd[5] && !h_wr[5] && !h_rd[0] && !h_wr[0];
    for (int k = 0; k < 4; k++)
      ok = ok && h_rd[4-k] && !h_wr[4-k] && (h_addr[4-k] == 14'(int'(c) + (bwd ? BO[k] : FO[k])));
    return ok;
  endfunction

  always @(negedge clk) begin
    if (mon_clr) begin
      rd_n <= 0; wr_n <= 0; both_n <= 0; border_n <= 0; proto_n <= 0; first_rd <= -1;
      for (int k = 0; k < 7; k++) begin
        h_rd[k] <= 1'b0; h_wr[k] <= 1'b0; h_addr[k] <= '0;
      end
    end else begin
      for (int k = 6; k > 0; k--) begin
        h_rd[k] <= h_rd[k-1]; h_wr[k] <= h_wr[k-1]; h_addr[k] <= h_addr[k-1];
      end
      h_rd[0] <= res_rd; h_wr[0] <= res_wr; h_addr[0] <= res_addr;
      if (res_rd) begin
        rd_n <= rd_n + 1;
        if (first_rd < 0) first_rd <= int'(res_addr);
      end
      if (res_wr) wr_n <= wr_n + 1;
      if (res_rd && res_wr) both_n <= both_n + 1;
      if ((res_rd || res_wr) && is_border(res_addr)) border_n <= border_n + 1;
      if (res_wr && !seq_ok(wr_n >= n_obj, res_addr)) proto_n <= proto_n + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < NPIX; i++) img[i] = 8'd0;
  endtask

  task automatic put_block(input int r0, input int c0, input int n);
    for (int r = r0; r < r0 + n; r++)
      for (int c = c0; c < c0 + n; c++) img[r*W + c] = 8'd1;
  endtask

  function automatic int min4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    if (d < m) m = d;
    return m;
  endfunction

  task automatic build_golden();
    int m, v;
    n_obj = 0;
    for (int i = 0; i < NPIX; i++) gold[i] = img[i];
    for (int r = 1; r <= W - 2; r++)
      for (int c = 1; c <= W - 2; c++)
        if (gold[r*W + c] != 0) begin
          n_obj++;
          m = min4(gold[(r-1)*W + c-1], gold[(r-1)*W + c], gold[(r-1)*W + c+1], gold[r*W + c-1]);
          gold[r*W + c] = 8'((m + 1 > 255) ? 255 : m + 1);
        end
    for (int r = W - 2; r >= 1; r--)
      for (int c = W - 2; c >= 1; c--)
        if (gold[r*W + c] != 0) begin
          m = min4(gold[(r+1)*W + c+1], gold[(r+1)*W + c], gold[(r+1)*W + c-1], gold[r*W + c+1]);
          v = (m + 1 > 255) ? 255 : m + 1;
          if (v < int'(gold[r*W + c])) gold[r*W + c] = 8'(v);
        end
  endtask

  task automatic load_and_clear();
    @(posedge clk); #1;
    load_req = 1'b1;
    mon_clr  = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    mon_clr  = 1'b0;
  endtask

  typedef struct {
    int row;
    int col;
    int exp_fwd;
    int exp_fin;
  } probe_t;

  probe_t probes [10];

  initial begin
    logic found, got_done, prev_busy, done_after_busy, busy_at_done;
    int   busy_cnt, bad_pix, done_low;

    probes[0] = '{50, 50, 1, 1};
    probes[1] = '{51, 51, 2, 2};
    probes[2] = '{52, 52, 3, 3};
    probes[3] = '{52, 53, 2, 2};
    probes[4] = '{54, 52, 3, 1};
    probes[5] = '{53, 52, 3, 2};
    probes[6] = '{54, 54, 1, 1};
    probes[7] = '{51, 53, 2, 2};
    probes[8] = '{5, 5, 1, 1};
    probes[9] = '{49, 50, 0, 0};

    // First image, aborted by reset while the forward pass is on row 20.
    clear_img();
    img[10*W + 10] = 8'd1;
    put_block(15, 30, 3);
    build_golden();
    load_and_clear();
    start = 1'b1;
    rstn  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30000 && !found; i++) begin
      @(negedge clk);
      if (res_rd && (res_addr[13:7] == 7'd20)) found = 1'b1;
    end
    check("reach_row20", 32'(found), 32'd1);
    #1;
    check("writes_before_row20", 32'(wr_n), 32'd10);
    rstn = 1'b0;
    #1;
    check("outputs_at_reset", 32'({res_rd, res_wr, busy, done, res_addr, res_do}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("outputs_held_reset", 32'({res_rd, res_wr, busy, done, res_addr, res_do}), 32'd0);

    // Fresh image: isolated pixel at (5,5) plus a 5x5 block at rows/cols 50..54.
    clear_img();
    img[5*W + 5] = 8'd1;
    put_block(50, 50, 5);
    build_golden();
    load_and_clear();
    start = 1'b1;
    rstn  = 1'b1;
    busy_cnt = 0; prev_busy = 1'b0; got_done = 1'b0; done_after_busy = 1'b0; busy_at_done = 1'b1;
    for (int cyc = 0; cyc < 70000 && !got_done; cyc++) begin
      @(negedge clk);
      if (done) begin
        got_done        = 1'b1;
        done_after_busy = prev_busy;
        busy_at_done    = busy;
      end else if (busy) busy_cnt++;
      prev_busy = busy;
      if (cyc == 100) start = 1'b0;
      if (cyc == 120) start = 1'b1;
      if (cyc == 121) start = 1'b0;
      if (cyc == 300) start = 1'b1;
    end
    #1;
    check("done_reached", 32'(got_done), 32'd1);
    check("busy_cycles", 32'(busy_cnt), 32'd63816);
    check("done_follows_busy", 32'(done_after_busy), 32'd1);
    check("busy_at_done", 32'(busy_at_done), 32'd0);
    check("first_read_addr", 32'(first_rd), 32'd129);
    check("read_count", 32'(rd_n), 32'd31960);
    check("write_count", 32'(wr_n), 32'd52);
    check("rd_wr_overlap", 32'(both_n), 32'd0);
    check("border_access", 32'(border_n), 32'd0);
    check("pixel_sequence", 32'(proto_n), 32'd0);
    check("writes_at_645", 32'(wr_cnt[645]), 32'd2);
    check("addr_6708_final", 32'(mem[6708]), 32'd3);
    bad_pix = 0;
    for (int i = 0; i < NPIX; i++) if (mem[i] !== gold[i]) bad_pix++;
    check("image_vs_model", 32'(bad_pix), 32'd0);
    for (int p = 0; p < 10; p++) begin
      check($sformatf("fwd(%0d,%0d)", probes[p].row, probes[p].col),
            32'(fwd_val[probes[p].row*W + probes[p].col]), 32'(probes[p].exp_fwd));
      check($sformatf("final(%0d,%0d)", probes[p].row, probes[p].col),
            32'(mem[probes[p].row*W + probes[p].col]), 32'(probes[p].exp_fin));
    end

    // start held high after completion must not restart anything.
    @(posedge clk); #1;
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    done_low = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!done || busy) done_low++;
    end
    #1;
    check("post_done_strobes", 32'(rd_n + wr_n), 32'd0);
    check("post_done_held", 32'(done_low), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dt_pass_sequencer.md
Name: dt_pass_sequencer

Overview:
- Runs the two-pass chessboard distance transform over the 128x128 result RAM once the bit-unpacking initializer has filled it with 0 (background) and 1 (object).
- Forward raster pass: each object pixel becomes min(NW,N,NE,W)+1.
- Backward raster pass: each object pixel becomes min(self, min(SE,S,SW,E)+1).
- Sole master of the res RAM port after start; asserts done when the image is final.

Parameters:
LOG_W, 7, log2 of image width/height (image is 2^LOG_W square)
ADDR_W, 14, res RAM address width (= 2*LOG_W)
DATA_W, 8, pixel width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  level; sampled only in IDLE (tied to initialize_done)
res_rd  out  1  read strobe
res_addr  out  ADDR_W  RAM address {row,col}
res_di  in  DATA_W  read data, valid the cycle after res_rd=1
res_wr  out  1  write strobe; write commits on the clk edge where res_wr=1
res_do  out  DATA_W  write data
busy  out  1  high from the cycle after start is accepted until done
done  out  1  high from pass completion until reset

Behaviour:
- Reset: clk is the clock; rstn is asynchronous and active-low.
  - On reset all outputs are 0 and the state is IDLE. Row/col/pass/accumulator registers are 0.
  - Reset mid-pass aborts immediately; RAM contents are left as partially written.
- Scan region: rows 1..126, cols 1..126 (generally 1..2^LOG_W-2). Border pixels are never read or written.
  - Forward pass: row-major ascending from (1,1) to (126,126).
  - Backward pass: descending from (126,126) to (1,1).
- Address = {row[LOG_W-1:0], col[LOG_W-1:0]}.
  - Forward neighbour order: NW(-129), N(-128), NE(-127), W(-1).
  - Backward neighbour order: SE(+129), S(+128), SW(+127), E(+1).
- States:
  - IDLE: outputs 0. If start=1, go to RD_C with pass=FWD at (1,1).
  - RD_C: res_rd=1, res_addr=centre.
  - CHK: res_di holds the centre.
    - If the centre is 0: advance position and go to RD_C, or to DONE after the last backward pixel.
    - Else: latch the centre into cen, set acc=all-ones, nb=0, go to RD_N.
  - RD_N: 4 cycles, nb=0..3. Each cycle drives res_rd=1 and res_addr=neighbour[nb].
    - For nb>=1, acc=min(acc,res_di).
    - After nb=3, go to LAST.
  - LAST: acc=min(acc,res_di); no read. Go to WR.
  - WR: res_wr=1, res_addr=centre.
    - Forward: res_do=sat(acc+1).
    - Backward: res_do=min(cen, sat(acc+1)).
    - Then advance position. After the last forward pixel switch pass=BWD at (126,126); after the last backward pixel go to DONE.
  - DONE: done=1, busy=0, RAM outputs 0. Stays in DONE until reset; start is ignored.
- Arithmetic: sat(x) clamps at 2^DATA_W-1 (255). min() is unsigned. The backward write occurs even when the value is unchanged.
- res_rd and res_wr are never both 1 in the same cycle. res_addr, res_do and res_wr are registered outputs.
- Timing:
  - Background pixel: 2 cycles. Object pixel: 8 cycles.
  - Passes run back-to-back with no gap cycle.
- busy=1 in every state except IDLE and DONE.

Decomposition:
- dt_pkg:
  - state enum (IDLE, RD_C, CHK, RD_N, LAST, WR, DONE)
  - pass enum (FWD, BWD)
  - LOG_W/ADDR_W/DATA_W defaults
  - signed neighbour offset table indexed [pass][nb]
  - first/last scan coordinates
- One sub-module, dt_addr_gen:
  - holds the row/col scan counters, pass direction and wrap logic
  - produces centre and neighbour addresses plus a last_pixel flag
  - the top FSM owns acc/cen and the RAM strobes.

Test Plan:
- All-zero RAM, start=1 -> res_wr never asserted; 2*2*15876=63504 cycles of scanning after leaving IDLE; done=1 on the next cycle and held; busy low after.
- Single 1 at (5,5) (addr 645) -> exactly two writes, both addr 645 data 1 (forward then backward); no reads of any row-0/127 or col-0/127 address.
- 5x5 block of 1s at rows/cols 50..54:
  - after the forward pass, (54,52)=3 and (52,53)=2;
  - final image: ring of 1 on the block edge, ring of 2 inside it, (52,52) = addr 6708 = 3.
- Protocol check throughout any run: res_di consumed only the cycle after res_rd; no cycle has res_rd&&res_wr; every object pixel gives the exact sequence RD_C,CHK,4xRD_N,LAST,WR.
- Reset mid-forward (rstn low while row=20): all outputs 0 within the reset, state IDLE. Re-release rstn with start=1 on a fresh image -> full correct result and done.
- start held high after done -> no further reads or writes for 1000 cycles; done stays 1. start pulsed 0->1 while busy -> no effect.
